sram_dp_be: RTL and testbench
=============================

Name: sram_dp_be

Overview:
- Parametrised simple-dual-port SRAM: one write port with byte enables, one independent read port.
- Read latency is selectable as 1 or 2 cycles, and the read-during-write result is selectable.
- A built-in clear engine zeroes the whole array after reset or on request.
- Used as the generic on-chip buffer/register-file memory for datapath blocks; replaces the fixed 16x16 single-port array.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per byte-enable lane.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (write-through).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_start  in  1  one-cycle pulse requesting a full-array clear.
- clr_busy  out  1  high while the clear engine owns the array.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/BYTE_W  byte enables; bit k covers wr_data[k*BYTE_W +: BYTE_W].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data carries the result of an accepted read.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - rd_data = 0, rd_valid = 0, read pipeline stages = 0.
  - clr_busy = 1, clear counter = 0, FSM = CLEAR.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes 0 (all lanes) to address clr_cnt, then increments clr_cnt.
    - After the write at DEPTH-1, go to IDLE; clr_busy drops on that same edge.
    - A clear takes exactly DEPTH cycles with clr_busy high.
  - IDLE: clr_start = 1 moves to CLEAR with clr_cnt = 0 and clr_busy = 1 from the next edge.
  - clr_start while already in CLEAR is ignored; the counter is not restarted.
- During CLEAR:
  - wr_en and rd_en are ignored: no array write, and no read is accepted.
  - rd_valid stays 0 for reads issued in CLEAR.
  - Reads already in the pipeline before CLEAR began still complete normally.
- Write: with wr_en = 1 in IDLE at edge t, each lane k with wr_be[k] = 1 takes the wr_data lane; other lanes keep their value.
  - wr_be = 0 is a legal no-op.
- Read:
  - RD_LAT = 1: rd_en = 1 in IDLE at edge t gives rd_data = mem[rd_addr] and rd_valid = 1 after edge t.
  - RD_LAT = 2: the same result appears one edge later.
  - Back-to-back reads are supported every cycle; rd_valid is high once per accepted read.
  - When no read completes, rd_valid = 0 and rd_data holds its last value.
- Same-cycle read and write to the same address:
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the pre-write word with the enabled lanes replaced by wr_data.
  - Different addresses: no interaction.
- A write at edge t is visible to a read accepted at edge t+1 in both modes.
- Addresses wrap naturally, since ADDR_W covers DEPTH exactly; there are no out-of-range addresses.
- Reset asserted mid-clear or mid-read: pipeline flushes (rd_valid = 0) and the clear restarts from address 0 after release.
- Illegal parameters (RD_LAT not 1 or 2, or DATA_W not a multiple of BYTE_W) are caught by a generate-time check that triggers an elaboration error.

Decomposition:
- Shared package sram_pkg:
  - FSM state typedef (IDLE, CLEAR).
  - Constants RDW_OLD = 0 and RDW_NEW = 1.
  - Byte-lane merge function: old word, new word, byte enables -> merged word. Used by both the array write and write-through.
- One sub-module, sram_rd_pipe: parametrised by RD_LAT; carries data and valid, with async reset.
- Array and clear FSM live in the top level.

Test Plan:
- Reset release: clr_busy = 1 for exactly 16 cycles, then 0; reads of addresses 0..15 all return 0x0000 with rd_valid pulses.
- Write 0xA5C3 to address 3 with wr_be = 2'b11, then write 0x00FF to address 3 with wr_be = 2'b01; a read of address 3 returns 0xA5FF. Check with RD_LAT = 1 and with RD_LAT = 2: rd_valid arrives 1 or 2 edges after rd_en respectively.
- mem[7] = 0x1234; in the same cycle write 0xBEEF to address 7 with wr_be = 2'b10 and read address 7. RDW_MODE = 0 returns 0x1234; RDW_MODE = 1 returns 0xBE34. A read the next cycle returns 0xBE34 in both modes.
- Streaming: reads of addresses 0..15 on consecutive cycles give 16 consecutive rd_valid cycles with data in address order. Writes to address 15 then address 0 confirm the wrap boundary.
- Fill the array with nonzero data, pulse clr_start, and issue rd_en/wr_en during the clear:
  - no rd_valid and no write during the clear;
  - a second clr_start mid-clear does not extend the busy time beyond 16 cycles;
  - all locations read 0 afterwards.
- Assert rst_n low at clear cycle 5 and at a point where a read is in flight:
  - rd_valid and rd_data go to 0 immediately;
  - after release, clr_busy is high for a full 16 cycles.

Source files
------------

// File: rtl/sram_dp_be_pkg.sv
// Shared types, constants and the byte-lane merge used by the sram_dp_be
// array write path and its write-through read path.
package sram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_W  = 512;
  localparam int MAX_AW = $clog2(MAX_W);

  function automatic logic [MAX_W-1:0] be_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] be,
    input int               byte_w
  );
    logic [MAX_W-1:0] res;
    int               lane;
    res = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      lane = i / byte_w;
      if (be[lane[MAX_AW-1:0]]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_dp_be_rd_pipe.sv
// Read-data pipeline for sram_dp_be: one or two registered stages, with the
// valid flag travelling alongside the data and data held between reads.
module sram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_p0_q;
  logic [DATA_W-1:0] data_p0_q;

  // Stage p0: word captured on the edge that accepts the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      vld_p0_q <= vld_i;
      if (vld_i) data_p0_q <= data_i;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              vld_p1_q;
    logic [DATA_W-1:0] data_p1_q;

    // Stage p1: extra output register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1_q  <= 1'b0;
        data_p1_q <= '0;
      end else begin
        vld_p1_q <= vld_p0_q;
        if (vld_p0_q) data_p1_q <= data_p0_q;
      end
    end

    assign vld_o  = vld_p1_q;
    assign data_o = data_p1_q;
  end else begin : g_lat1
    assign vld_o  = vld_p0_q;
    assign data_o = data_p0_q;
  end

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte-enable writes, 1- or 2-cycle reads,
// selectable read-during-write result and a whole-array clear engine.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_start,
  output logic                     clr_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("sram_dp_be: RD_LAT must be 1 or 2");
  end

  if ((DATA_W % BYTE_W) != 0 || DATA_W > MAX_W) begin : g_bad_width
    $error("sram_dp_be: DATA_W must be a multiple of BYTE_W and fit the merge helper");
  end

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clr_busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_fire_d;
  logic              rd_fire_d;
  logic [DATA_W-1:0] wr_word_d;
  logic [DATA_W-1:0] rd_word_d;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    return DATA_W'(be_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_W'(be), BYTE_W));
  endfunction

  // Clear FSM: busy is registered so it drops on the edge of the last clear write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= CLEAR;
          clr_cnt_q  <= '0;
          clr_busy_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_fire_d = wr_en && (state_q == IDLE);
    rd_fire_d = rd_en && (state_q == IDLE);
    wr_word_d = merge_lanes(mem_q[wr_addr], wr_data, wr_be);
    rd_word_d = mem_q[rd_addr];
    if (RDW_MODE == RDW_NEW && wr_fire_d && (wr_addr == rd_addr))
      rd_word_d = merge_lanes(mem_q[rd_addr], wr_data, wr_be);
  end

  // Storage is deliberately unreset; the clear engine owns initialisation
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[clr_cnt_q] <= '0;
    else if (wr_fire_d)   mem_q[wr_addr]   <= wr_word_d;
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (rd_fire_d),
    .data_i (rd_word_d),
    .vld_o  (rd_valid),
    .data_o (rd_data)
  );

  assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: four instances (RD_LAT 1/2 x RDW_MODE old/new) share
// one stimulus stream and are checked against a queue-based memory model.
module tb_sram_dp_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b1;
  logic        clr_start = 1'b0;
  logic        wr_en     = 1'b0;
  logic [3:0]  wr_addr   = 4'd0;
  logic [1:0]  wr_be     = 2'b00;
  logic [15:0] wr_data   = 16'h0;
  logic        rd_en     = 1'b0;
  logic [3:0]  rd_addr   = 4'd0;

  logic [15:0] rd_data_w  [4];
  logic        rd_valid_w [4];
  logic        clr_busy_w [4];

  // Instance g: RD_LAT = 1 + g/2, RDW_MODE = g%2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_dp_be #(
      .DATA_W   (16),
      .BYTE_W   (8),
      .ADDR_W   (4),
      .RD_LAT   (1 + g / 2),
      .RDW_MODE (g % 2)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_start (clr_start),
      .clr_busy  (clr_busy_w[g]),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_be     (wr_be),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data_w[g]),
      .rd_valid  (rd_valid_w[g])
    );
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [15:0] d_old;
    logic [15:0] d_new;
  } rd_t;

  logic [15:0] mmem [16];
  rd_t         q_lat1 [$];
  rd_t         q_lat2 [$];
  int          edge_n = 0;
  int          clr_left = 0;
  logic [3:0]  clr_ptr = 4'd0;
  logic        exp_valid [4];
  logic [15:0] exp_data  [4];
  logic        exp_busy = 1'b1;

  function automatic logic [15:0] lane_merge(input logic [15:0] o, input logic [15:0] n,
                                             input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  task automatic reset_model();
    q_lat1.delete();
    q_lat2.delete();
    for (int g = 0; g < 4; g++) begin
      exp_valid[g] = 1'b0;
      exp_data[g]  = 16'h0;
    end
    clr_left = 16;
    clr_ptr  = 4'd0;
    exp_busy = 1'b1;
  endtask

  task automatic model_edge();
    logic [15:0] old_w, new_w;
    rd_t r;
    edge_n++;
    if (clr_left > 0) begin
      mmem[clr_ptr] = 16'h0;
      clr_ptr++;
      clr_left--;
    end else begin
      if (rd_en) begin
        old_w = mmem[rd_addr];
        new_w = (wr_en && wr_addr == rd_addr) ? lane_merge(old_w, wr_data, wr_be) : old_w;
        q_lat1.push_back('{edge_n, old_w, new_w});
        q_lat2.push_back('{edge_n + 1, old_w, new_w});
      end
      if (wr_en) mmem[wr_addr] = lane_merge(mmem[wr_addr], wr_data, wr_be);
      if (clr_start) begin
        clr_left = 16;
        clr_ptr  = 4'd0;
      end
    end
    for (int g = 0; g < 4; g++) exp_valid[g] = 1'b0;
    if (q_lat1.size() > 0 && q_lat1[0].due == edge_n) begin
      r = q_lat1.pop_front();
      exp_valid[0] = 1'b1; exp_data[0] = r.d_old;
      exp_valid[1] = 1'b1; exp_data[1] = r.d_new;
    end
    if (q_lat2.size() > 0 && q_lat2[0].due == edge_n) begin
      r = q_lat2.pop_front();
      exp_valid[2] = 1'b1; exp_data[2] = r.d_old;
      exp_valid[3] = 1'b1; exp_data[3] = r.d_new;
    end
    exp_busy = (clr_left > 0);
  endtask

  task automatic step(input logic we, input logic [3:0] wa, input logic [1:0] be,
                      input logic [15:0] wd, input logic re, input logic [3:0] ra,
                      input logic cs);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_start = cs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    int pulses [4];
    #1;
    rst_n = 1'b0;
    reset_model();
    #1;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rd_valid_w[g] !== 1'b0 || rd_data_w[g] !== 16'h0 || clr_busy_w[g] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state inst%0d: got v=%0b d=%h busy=%0b want v=0 d=0000 busy=1",
                 g, rd_valid_w[g], rd_data_w[g], clr_busy_w[g]);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      idle();
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (clr_busy_w[g] !== (i < 16)) begin
          errors++;
          $display("FAIL reset_busy inst%0d cycle%0d: got %0b want %0b", g, i, clr_busy_w[g], i < 16);
        end
      end
    end
    for (int g = 0; g < 4; g++) pulses[g] = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 4'd0, 2'b00, 16'h0, i < 16, 4'(i), 1'b0);
      for (int g = 0; g < 4; g++) begin
        if (rd_valid_w[g] === 1'b1) pulses[g]++;
        checks++;
        if (rd_valid_w[g] !== exp_valid[g] || (exp_valid[g] && rd_data_w[g] !== 16'h0)) begin
          errors++;
          $display("FAIL reset_zero inst%0d step%0d: got v=%0b d=%h want v=%0b d=0000",
                   g, i, rd_valid_w[g], rd_data_w[g], exp_valid[g]);
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (pulses[g] != 16) begin
        errors++;
        $display("FAIL reset_pulses inst%0d: got %0d want 16", g, pulses[g]);
      end
    end
  endtask

  task automatic test_byte_en();
    step(1'b1, 4'd3, 2'b11, 16'hA5C3, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd3, 2'b01, 16'h00FF, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd3, 1'b0);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rd_valid_w[g] !== (g < 2) || (g < 2 && rd_data_w[g] !== 16'hA5FF)) begin
        errors++;
        $display("FAIL byte_en_lat_e1 inst%0d: got v=%0b d=%h want v=%0b d=a5ff",
                 g, rd_valid_w[g], rd_data_w[g], g < 2);
      end
    end
    idle();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rd_valid_w[g] !== (g >= 2) || rd_data_w[g] !== 16'hA5FF) begin
        errors++;
        $display("FAIL byte_en_lat_e2 inst%0d: got v=%0b d=%h want v=%0b d=a5ff",
                 g, rd_valid_w[g], rd_data_w[g], g >= 2);
      end
    end
  endtask

  task automatic test_rdw();
    logic [15:0] want;
    step(1'b1, 4'd7, 2'b11, 16'h1234, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd7, 2'b10, 16'hBEEF, 1'b1, 4'd7, 1'b0);
    step(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd7, 1'b0);
    for (int g = 0; g < 4; g++) begin
      want = (g < 2) ? 16'hBE34 : ((g == 2) ? 16'h1234 : 16'hBE34);
      checks++;
      if (rd_valid_w[g] !== 1'b1 || rd_data_w[g] !== want) begin
        errors++;
        $display("FAIL rdw_mode inst%0d: got v=%0b d=%h want v=1 d=%h", g, rd_valid_w[g], rd_data_w[g], want);
      end
    end
    idle();
    for (int g = 2; g < 4; g++) begin
      checks++;
      if (rd_valid_w[g] !== 1'b1 || rd_data_w[g] !== 16'hBE34) begin
        errors++;
        $display("FAIL rdw_next inst%0d: got v=%0b d=%h want v=1 d=be34", g, rd_valid_w[g], rd_data_w[g]);
      end
    end
    step(1'b1, 4'd7, 2'b00, 16'hFFFF, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd7, 1'b0);
    idle();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (rd_data_w[g] !== 16'hBE34) begin
        errors++;
        $display("FAIL be_zero_noop inst%0d: got d=%h want d=be34", g, rd_data_w[g]);
      end
    end
  endtask

  task automatic test_stream();
    int pulses [4];
    logic [3:0] ra;
    for (int a = 0; a < 16; a++)
      step(1'b1, 4'(a), 2'b11, 16'($urandom_range(1, 16'hFFFF)), 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd15, 2'b11, 16'hF00F, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd0,  2'b11, 16'h0FF0, 1'b0, 4'd0, 1'b0);
    for (int g = 0; g < 4; g++) pulses[g] = 0;
    for (int i = 0; i < 20; i++) begin
      ra = (i < 16) ? 4'(i) : ((i == 16) ? 4'd15 : 4'd0);
      step(1'b0, 4'd0, 2'b00, 16'h0, i < 18, ra, 1'b0);
      for (int g = 0; g < 4; g++) begin
        if (rd_valid_w[g] === 1'b1) pulses[g]++;
        checks++;
        if (rd_valid_w[g] !== exp_valid[g] || rd_data_w[g] !== exp_data[g]) begin
          errors++;
          $display("FAIL stream inst%0d step%0d: got v=%0b d=%h want v=%0b d=%h",
                   g, i, rd_valid_w[g], rd_data_w[g], exp_valid[g], exp_data[g]);
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (pulses[g] != 18) begin
        errors++;
        $display("FAIL stream_pulses inst%0d: got %0d want 18", g, pulses[g]);
      end
    end
  endtask

  task automatic test_clear();
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 4'd0, 2'b11, 16'($urandom_range(1, 16'hFFFF)), 1'b1, 4'($urandom), i == 5);
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (clr_busy_w[g] !== (i < 16) || (i >= 2 && rd_valid_w[g] !== 1'b0) ||
            rd_valid_w[g] !== exp_valid[g] || rd_data_w[g] !== exp_data[g]) begin
          errors++;
          $display("FAIL clear_busy inst%0d cycle%0d: got busy=%0b v=%0b d=%h want busy=%0b v=%0b d=%h",
                   g, i, clr_busy_w[g], rd_valid_w[g], rd_data_w[g], i < 16, exp_valid[g], exp_data[g]);
        end
      end
    end
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 4'd0, 2'b00, 16'h0, i < 16, 4'(i), 1'b0);
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rd_valid_w[g] !== exp_valid[g] || (exp_valid[g] && rd_data_w[g] !== 16'h0)) begin
          errors++;
          $display("FAIL clear_zero inst%0d step%0d: got v=%0b d=%h want v=%0b d=0000",
                   g, i, rd_valid_w[g], rd_data_w[g], exp_valid[g]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        step(1'b1, 4'd9, 2'b11, 16'h5A5A, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd9, 1'b0);
      end else begin
        step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) idle();
      end
      rst_n = 1'b0;
      reset_model();
      #1;
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rd_valid_w[g] !== 1'b0 || rd_data_w[g] !== 16'h0 || clr_busy_w[g] !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid%0d inst%0d: got v=%0b d=%h busy=%0b want v=0 d=0000 busy=1",
                   pass, g, rd_valid_w[g], rd_data_w[g], clr_busy_w[g]);
        end
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        idle();
        for (int g = 0; g < 4; g++) begin
          checks++;
          if (clr_busy_w[g] !== (i < 16) || rd_valid_w[g] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid%0d_busy inst%0d cycle%0d: got busy=%0b v=%0b want busy=%0b v=0",
                     pass, g, i, clr_busy_w[g], rd_valid_w[g], i < 16);
          end
        end
      end
    end
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 4'd0, 2'b00, 16'h0, i < 16, 4'(i), 1'b0);
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rd_valid_w[g] !== exp_valid[g] || (exp_valid[g] && rd_data_w[g] !== 16'h0)) begin
          errors++;
          $display("FAIL reset_mid_zero inst%0d step%0d: got v=%0b d=%h want v=%0b d=0000",
                   g, i, rd_valid_w[g], rd_data_w[g], exp_valid[g]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic narrow;
    for (int i = 0; i < 400; i++) begin
      narrow = 1'($urandom);
      step(1'($urandom), narrow ? 4'($urandom_range(0, 3)) : 4'($urandom), 2'($urandom),
           16'($urandom), 1'($urandom), narrow ? 4'($urandom_range(0, 3)) : 4'($urandom),
           $urandom_range(0, 63) == 0);
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rd_valid_w[g] !== exp_valid[g] || rd_data_w[g] !== exp_data[g] ||
            clr_busy_w[g] !== exp_busy) begin
          errors++;
          $display("FAIL random inst%0d edge%0d: got v=%0b d=%h busy=%0b want v=%0b d=%h busy=%0b",
                   g, edge_n, rd_valid_w[g], rd_data_w[g], clr_busy_w[g],
                   exp_valid[g], exp_data[g], exp_busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_rdw();
    test_stream();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
